ifetch: RTL
===========

# ifetch

Instruction fetch stage for the cpu32 core. Sits directly upstream of decode/execute: it drives the synchronous instruction SRAM and buffers returned words in a 2-entry queue. It presents one instruction per cycle, with its PC, to the downstream stage. It absorbs downstream stalls without losing in-flight reads, and accepts branch redirects that flush all fetched-but-unconsumed work.

## Interface
Parameters:
- RESET_PC, 32'h00000000, fetch address loaded at reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; asserted when 0
- i_addr  out  32  instruction SRAM address; word aligned, bits [1:0] always 0
- i_rd  out  1  read strobe; a read issued in cycle N returns on i_data in cycle N+1
- i_data  in  32  SRAM read data; valid in the cycle after an i_rd cycle
- out_valid  out  1  out_ir/out_pc hold a fetched instruction
- out_ir  out  32  instruction word at queue head
- out_pc  out  32  address of out_ir
- in_stall  in  1  downstream not accepting; the head is consumed on an edge where out_valid=1 and in_stall=0
- in_redirect  in  1  branch taken; flush and refetch from in_target
- in_target  in  32  redirect address; bits [1:0] ignored (treated as 0)

## Operation
- State:
  - fpc: next fetch address.
  - Inflight flag plus inflight pc: one SRAM read outstanding.
  - Queue: 2 entries of {pc, ir}, with 2-bit count, head pointer and tail pointer.
- pop = out_valid & !in_stall. push = inflight & !in_redirect; on push, the pair {inflight pc, i_data} is written at the tail.
- Issue rule: i_rd = reset_deasserted & ((count + inflight - pop < 2) | in_redirect).
  - Occupancy never exceeds 2. Every issued read always has a slot.
- Normal issue:
  - i_addr = fpc.
  - On the edge: inflight pc <= fpc, fpc <= fpc + 4.
  - The 32-bit add wraps, so 32'hFFFFFFFC is followed by 32'h00000000.
- Redirect (in_redirect=1 in cycle N) has priority over stall, pop and push:
  - i_addr = {in_target[31:2], 2'b00} combinationally, with i_rd=1.
  - On the edge: queue cleared (count=0, pointers=0). The response landing in cycle N is discarded. Inflight pc <= target; fpc <= target + 4.
  - The head instruction presented in cycle N is not consumed.
- When not redirecting, i_rd=0 leaves fpc and the inflight state unchanged (inflight <= 0 after the response lands).
- Outputs:
  - out_valid = (count != 0).
  - out_ir/out_pc = head entry when count != 0. When empty, drive 32'h0.
  - The queue is not bypassed: a word is visible the cycle after it returns.
- Simultaneous push and pop: count unchanged; both pointers advance mod 2.

## Timing
- Reset asserted (any time, including mid-fetch or mid-redirect):
  - Immediately: out_valid=0, out_ir=0, out_pc=0, i_rd=0, i_addr=RESET_PC.
  - fpc=RESET_PC, inflight=0, count=0.
- First cycle after release (cycle 0): i_rd=1 at RESET_PC. Data returns in cycle 1. out_valid=1 with out_pc=RESET_PC in cycle 2.
- Steady state with no stall: one instruction per cycle; out_pc advances by 4 each cycle.
- Stall:
  - out_ir/out_pc/out_valid are held stable for every cycle in_stall=1.
  - The queue fills to 2 and issue stops.
- Stall release: an issue is made in the same cycle. There is no bubble: the second entry covers the SRAM latency.
- Redirect:
  - Redirect in cycle N: out_valid=0 in cycle N+1.
  - Target instruction valid in cycle N+2.
  - Target+4 follows in N+3 if not stalled.
- Back-to-back redirects: the last one wins; each one restarts the 2-cycle latency.

## Test plan
- Reset release with RESET_PC=0x100, SRAM returning addr^0xA5A5A5A5, no stall:
  - out_valid rises in cycle 2.
  - out_pc sequence 0x100, 0x104, 0x108..., with matching out_ir.
  - i_rd high every cycle.
- Stall held 5 cycles starting when out_pc=0x108:
  - out_pc/out_ir frozen at 0x108.
  - i_rd drops once count=2.
  - After release: 0x10C, 0x110 on consecutive cycles, none skipped or duplicated.
- Redirect to 0x2003 while the queue holds 2 entries and a read is in flight:
  - out_valid=0 next cycle; out_pc=0x2000 two cycles after the redirect.
  - No stale PC ever appears on the output.
- Redirect asserted together with in_stall=1: the redirect wins; the same sequence as the previous scenario.
- Fetch across wrap (RESET_PC=0xFFFFFFF8): out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset asserted asynchronously mid-stream (between edges):
  - out_valid, out_ir and out_pc go to 0 without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC with the same 2-cycle latency.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage driving a 1-cycle-latency instruction SRAM,
// buffering returned words in a 2-entry queue and presenting one per cycle.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  output logic        i_rd,
  input  logic [31:0] i_data,
  output logic        out_valid,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [31:0] in_target
);
  logic [31:0] fpc, ipc, tgt;
  logic        inflight, head, tail, pop, push;
  logic [1:0]  count;
  logic [2:0]  occ;
  logic [31:0] q_pc [2];
  logic [31:0] q_ir [2];
  always_comb begin
    tgt = in_target & 32'hFFFF_FFFC;
    out_valid = count != 2'd0;
    out_pc = out_valid ? q_pc[head] : 32'h0;
    out_ir = out_valid ? q_ir[head] : 32'h0;
    pop = out_valid & ~in_stall;
    push = inflight & ~in_redirect;
    // occupancy after this edge, counting the read in flight as a reserved slot
    occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    i_rd = reset & ((occ < 3'd2) | in_redirect);
    i_addr = !reset ? RESET_PC : in_redirect ? tgt : fpc;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc <= RESET_PC;
      ipc <= RESET_PC;
      inflight <= 1'b0;
      count <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else if (in_redirect) begin
      fpc <= tgt + 32'd4;
      ipc <= tgt;
      inflight <= 1'b1;
      count <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      inflight <= i_rd;
      if (i_rd) begin
        ipc <= fpc;
        fpc <= fpc + 32'd4;
      end
      if (push) tail <= ~tail;
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  // payload storage needs no reset: it is only observed while count != 0
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail] <= ipc;
      q_ir[tail] <= i_data;
    end
  end
endmodule
